// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, default timing
// constants, frame length and the odd-parity helper.
package ps2_pkg;

  localparam int RTS_CYCLES_DEF     = 5000;
  localparam int TIMEOUT_CYCLES_DEF = 750000;
  localparam int FILTER_LEN_DEF     = 8;
  localparam int FRAME_BITS         = 11;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RTS       = 3'd1,
    S_REQ       = 3'd2,
    S_DATA      = 3'd3,
    S_PARITY    = 3'd4,
    S_STOP      = 3'd5,
    S_ACK       = 3'd6,
    S_WAIT_IDLE = 3'd7
  } ps2_state_e;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_tx_if.sv
// Host-side command strobe, status pulses and PS/2 pad signals of ps2_tx.
// Handshake: wr is a one-cycle strobe taken only while busy is low; din is
// captured with it, and exactly one of done/err pulses when busy drops.
interface ps2_tx_if;
  import ps2_pkg::*;

  logic       wr;
  logic [7:0] din;
  logic       busy;
  logic       done;
  logic       err;
  logic       ps2c_in;
  logic       ps2d_in;
  logic       ps2c_oe;
  logic       ps2d_oe;
  ps2_state_e state_dbg;

  modport master (
    output wr, din, ps2c_in, ps2d_in,
    input  busy, done, err, ps2c_oe, ps2d_oe, state_dbg
  );

  modport slave (
    input  wr, din, ps2c_in, ps2d_in,
    output busy, done, err, ps2c_oe, ps2d_oe, state_dbg
  );

endinterface

// File: rtl/ps2_clk_filter.sv
// Two-flop synchronisers for the PS/2 pads plus a run-length glitch filter
// on the clock line with a one-cycle falling-edge tick.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c_in,
  input  logic ps2d_in,
  output logic c_filt,
  output logic d_sync,
  output logic fall_tick
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    c_sync_q;
  logic [1:0]    d_sync_q;
  logic [CW-1:0] run_q;
  logic          c_s;

  assign c_s    = c_sync_q[1];
  assign d_sync = d_sync_q[1];

  // run_q counts consecutive samples disagreeing with the filtered level.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_sync_q  <= 2'b11;
      d_sync_q  <= 2'b11;
      run_q     <= '0;
      c_filt    <= 1'b1;
      fall_tick <= 1'b0;
    end else begin
      c_sync_q  <= {c_sync_q[0], ps2c_in};
      d_sync_q  <= {d_sync_q[0], ps2d_in};
      fall_tick <= 1'b0;
      if (c_s == c_filt) begin
        run_q <= '0;
      end else if (run_q == CW'(FILTER_LEN - 1)) begin
        c_filt    <= c_s;
        run_q     <= '0;
        fall_tick <= c_filt;
      end else begin
        run_q <= run_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device command transmitter: clock inhibit, start bit, eight
// data bits LSB-first, odd parity, stop, device ACK check and bus-idle wait.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int RTS_CYCLES     = RTS_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int FILTER_LEN     = FILTER_LEN_DEF
) (
  input logic     clk,
  input logic     reset,
  ps2_tx_if.slave bus
);

  localparam logic [2:0] ST_IDLE      = S_IDLE;
  localparam logic [2:0] ST_RTS       = S_RTS;
  localparam logic [2:0] ST_REQ       = S_REQ;
  localparam logic [2:0] ST_DATA      = S_DATA;
  localparam logic [2:0] ST_PARITY    = S_PARITY;
  localparam logic [2:0] ST_STOP      = S_STOP;
  localparam logic [2:0] ST_ACK       = S_ACK;
  localparam logic [2:0] ST_WAIT_IDLE = S_WAIT_IDLE;

  localparam int DATA_BITS = FRAME_BITS - 3;
  localparam int CNT_MAX   = (RTS_CYCLES > TIMEOUT_CYCLES) ? RTS_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  logic [2:0]       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       data_q;
  logic             par_q;
  logic [2:0]       bit_q;
  logic             done_q;
  logic             err_q;
  logic             c_filt;
  logic             d_sync;
  logic             fall_tick;
  logic             c_oe;
  logic             d_oe;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk       (clk),
    .reset     (reset),
    .ps2c_in   (bus.ps2c_in),
    .ps2d_in   (bus.ps2d_in),
    .c_filt    (c_filt),
    .d_sync    (d_sync),
    .fall_tick (fall_tick)
  );

  // cnt_q times the inhibit in RTS, then restarts at REQ entry as the
  // transfer timeout; the timeout check takes priority over any fall tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      bit_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= cnt_q + 1'b1;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (bus.wr) begin
            data_q  <= bus.din;
            par_q   <= odd_parity(bus.din);
            bit_q   <= '0;
            state_q <= ST_RTS;
          end
        end
        ST_RTS: begin
          if (cnt_q == CNT_W'(RTS_CYCLES - 1)) begin
            cnt_q   <= '0;
            state_q <= ST_REQ;
          end
        end
        default: begin
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b1;
          end else begin
            case (state_q)
              ST_REQ:    if (fall_tick) state_q <= ST_DATA;
              ST_DATA: begin
                if (fall_tick) begin
                  if (bit_q == 3'(DATA_BITS - 1)) state_q <= ST_PARITY;
                  else                            bit_q   <= bit_q + 1'b1;
                end
              end
              ST_PARITY: if (fall_tick) state_q <= ST_STOP;
              ST_STOP:   if (fall_tick) state_q <= ST_ACK;
              ST_ACK: begin
                if (fall_tick) begin
                  state_q <= d_sync ? ST_IDLE : ST_WAIT_IDLE;
                  err_q   <= d_sync;
                end
              end
              ST_WAIT_IDLE: begin
                if (c_filt && d_sync) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b1;
                end
              end
              default: state_q <= ST_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  always_comb begin
    c_oe = 1'b0;
    d_oe = 1'b0;
    case (state_q)
      ST_RTS: begin
        c_oe = 1'b1;
        d_oe = (cnt_q == CNT_W'(RTS_CYCLES - 1));
      end
      ST_REQ:    d_oe = 1'b1;
      ST_DATA:   d_oe = ~data_q[bit_q];
      ST_PARITY: d_oe = ~par_q;
      default:   ;
    endcase
  end

  assign bus.ps2c_oe   = c_oe;
  assign bus.ps2d_oe   = d_oe;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.state_dbg = ps2_state_e'(state_q);

endmodule
